// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, models MDU latency with a
// down-counter and raises the D-stage stall for MDU users while busy.
module md_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          sgn;
    logic [63:0]   prod;
    logic [31:0]   da, db, uq, ur;
    logic [31:0]   res_hi, res_lo;
    logic          long_op;

    assign long_op = (op == OP_MULT) || (op == OP_MULTU) ||
                     (op == OP_DIV)  || (op == OP_DIVU);

    // Result datapath works only from the latched operands.
    always_comb begin
        sgn    = (op_q == OP_MULT) || (op_q == OP_DIV);
        prod   = '0;
        da     = (sgn && a_q[31]) ? (~a_q + 32'd1) : a_q;
        db     = (sgn && b_q[31]) ? (~b_q + 32'd1) : b_q;
        uq     = (db == 32'd0) ? 32'd0 : da / db;
        ur     = (db == 32'd0) ? 32'd0 : da % db;
        res_hi = '0;
        res_lo = '0;
        if (op_q == OP_MULT || op_q == OP_MULTU) begin
            if (sgn)
                prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
            else
                prod = {32'd0, a_q} * {32'd0, b_q};
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (b_q == 32'd0) begin
            res_hi = a_q;
            res_lo = 32'hFFFF_FFFF;
        end else if (sgn && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            res_hi = 32'd0;
            res_lo = 32'h8000_0000;
        end else begin
            res_lo = (sgn && (a_q[31] ^ b_q[31])) ? (~uq + 32'd1) : uq;
            res_hi = (sgn && a_q[31]) ? (~ur + 32'd1) : ur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (start && long_op) begin
                    state_d = RUN;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = (op == OP_MULT || op == OP_MULTU) ?
                              CW'(MULT_CYC) : CW'(DIV_CYC);
                end else if (start && op == OP_MTHI) begin
                    hi_d = a;
                end else if (start && op == OP_MTLO) begin
                    lo_d = a;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall is kept off the HI/LO path on purpose.
    always_comb begin
        busy  = (state_q == RUN);
        stall = d_md_use & (busy | (start & long_op));
        hi    = hi_q;
        lo    = lo_q;
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed-vector bench for md_sched.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int nvec = 0;
    int nerr = 0;

    md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .d_md_use(d_md_use),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a long op, check busy/stall every busy cycle, then the result.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input int n, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic use_d);
        op = o; a = x; b = y; start = 1'b1; d_md_use = use_d;
        #1;
        chk({tag, "_stall0"}, {31'd0, stall}, {31'd0, use_d});
        tick();
        start = 1'b0; op = 3'd0; a = 32'hDEAD_BEEF; b = 32'h0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_stall"}, {31'd0, stall}, {31'd0, use_d});
            tick();
        end
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_nstall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        d_md_use = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0;
        a = '0; b = '0; d_md_use = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_nb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10,
               32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("divu0", 3'd4, 32'd7, 32'd0, 10,
               32'd7, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'd0, 32'h8000_0000, 1'b0);
        run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, 10,
               32'd1, 32'h7FFF_FFFC, 1'b0);
        run_op("div_stall", 3'd3, 32'd100, 32'd7, 10,
               32'd2, 32'd14, 1'b1);

        // mthi / mtlo in idle
        op = 3'd5; a = 32'h1234; start = 1'b1; d_md_use = 1'b1;
        #1;
        chk("mthi_stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0; d_md_use = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_lo", lo, 32'd14);
        op = 3'd6; a = 32'h5678; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_hi", hi, 32'h1234);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // Start during a busy div is ignored
        op = 3'd3; a = 32'd20; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        op = 3'd1; a = 32'd0; b = 32'd0; start = 1'b1;
        tick();
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < 7; i++) tick();
        chk("ign_busy", {31'd0, busy}, 32'd0);
        chk("ign_hi", hi, 32'd2);
        chk("ign_lo", lo, 32'd6);

        // Reset aborts an in-flight div
        op = 3'd5; a = 32'd5; start = 1'b1;
        tick();
        chk("pre_hi", hi, 32'd5);
        op = 3'd3; a = 32'd50; b = 32'd5;
        tick();
        start = 1'b0; op = 3'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; d_md_use = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("late_hi", hi, 32'd0);
        chk("late_lo", lo, 32'd0);
        chk("late_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
